// File: rtl/ppu_fb_writer.sv
// PPU pixel-stream sink: packs 2bpp pixels four to a byte, queues them with their
// framebuffer address, and drains the queue through a valid/ready RAM write port.
module ppu_fb_writer #(
  parameter int FIFO_DEPTH  = 4,
  parameter bit DOUBLE_BUF  = 1'b1,
  parameter int BANK_STRIDE = 5760
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PX_OUT,
  input  logic        PX_valid,
  input  logic [1:0]  PPU_MODE,
  output logic        FB_WR,
  output logic [13:0] FB_ADDR,
  output logic [7:0]  FB_DATA,
  input  logic        FB_READY,
  output logic        FB_BANK,
  output logic        FRAME_DONE,
  output logic        LINE_ERR,
  output logic        OVF,
  input  logic        ERR_CLR
);

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } ppu_mode_t;

  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     CNT_ONE  = 1;
  localparam logic [AW-1:0]   PTR_ONE  = 1;
  localparam logic [7:0]      LINE_W   = 8'd160;
  localparam logic [7:0]      LAST_Y   = 8'd143;

  ppu_mode_t   mode;
  ppu_mode_t   prev_mode;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [1:0]  k;
  logic [7:0]  shift;
  logic [7:0]  shift_next;
  logic        bank;

  logic [13:0] mem_addr [FIFO_DEPTH];
  logic [7:0]  mem_data [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  logic        px_accept;
  logic        line_end;
  logic        frame_end;
  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic        full;
  logic [7:0]  push_data;
  logic [13:0] push_addr;
  logic [13:0] bank_base;
  logic [13:0] row_base;

  assign mode      = ppu_mode_t'(PPU_MODE);
  assign px_accept = PX_valid && (mode == DRAW) && (x < LINE_W);
  assign line_end  = (prev_mode == DRAW) && (mode != DRAW);
  assign frame_end = (prev_mode != V_BLANK) && (mode == V_BLANK);

  always_comb begin
    shift_next = shift;
    case (k)
      2'd0:    shift_next[7:6] = PX_OUT;
      2'd1:    shift_next[5:4] = PX_OUT;
      2'd2:    shift_next[3:2] = PX_OUT;
      default: shift_next[1:0] = PX_OUT;
    endcase
  end

  // x and k advance together, so x/4 is always the group of the first pixel in the byte
  assign bank_base = bank ? 14'(BANK_STRIDE) : 14'd0;
  assign row_base  = 14'(y) * 14'd40;
  assign push_addr = bank_base + row_base + {8'd0, x[7:2]};
  assign push_data = px_accept ? shift_next : shift;
  assign push_req  = (px_accept && (k == 2'd3)) || (line_end && (k != 2'd0));

  assign full    = (count == CNT_FULL);
  assign pop     = (count != '0) && FB_READY;
  assign push_ok = push_req && (!full || pop);

  assign FB_WR      = (count != '0);
  assign FB_ADDR    = FB_WR ? mem_addr[rptr] : 14'd0;
  assign FB_DATA    = FB_WR ? mem_data[rptr] : 8'd0;
  assign FB_BANK    = bank;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_addr[wptr] <= push_addr;
      mem_data[wptr] <= push_data;
    end
  end

  // Line end is applied before frame end so a DRAW->V_BLANK edge leaves y at 0
  always_ff @(posedge clk) begin
    if (rst) begin
      x          <= 8'd0;
      y          <= 8'd0;
      k          <= 2'd0;
      shift      <= 8'd0;
      bank       <= 1'b0;
      prev_mode  <= V_BLANK;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      FRAME_DONE <= 1'b0;
      LINE_ERR   <= 1'b0;
      OVF        <= 1'b0;
    end else begin
      prev_mode  <= mode;
      FRAME_DONE <= frame_end;

      if (px_accept) begin
        x     <= x + 8'd1;
        k     <= k + 2'd1;
        shift <= (k == 2'd3) ? 8'd0 : shift_next;
      end

      if (line_end) begin
        x     <= 8'd0;
        k     <= 2'd0;
        shift <= 8'd0;
        y     <= (y < LAST_Y) ? y + 8'd1 : y;
      end

      if (frame_end) begin
        y <= 8'd0;
        if (DOUBLE_BUF) bank <= ~bank;
      end

      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop)     rptr <= rptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      if (line_end && (x != LINE_W)) LINE_ERR <= 1'b1;
      else if (ERR_CLR)              LINE_ERR <= 1'b0;

      if (push_req && !push_ok) OVF <= 1'b1;
      else if (ERR_CLR)         OVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Directed bench for ppu_fb_writer: a per-cycle vector table for the short-line
// handshake, plus hand-written sequences for lines, backpressure, frames and reset.
module tb_ppu_fb_writer;

  localparam logic [1:0] M_HB   = 2'd0;
  localparam logic [1:0] M_VB   = 2'd1;
  localparam logic [1:0] M_SCAN = 2'd2;
  localparam logic [1:0] M_DRAW = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  PX_OUT = 2'd0;
  logic        PX_valid = 1'b0;
  logic [1:0]  PPU_MODE = M_VB;
  logic        FB_WR;
  logic [13:0] FB_ADDR;
  logic [7:0]  FB_DATA;
  logic        FB_READY = 1'b0;
  logic        FB_BANK;
  logic        FRAME_DONE;
  logic        LINE_ERR;
  logic        OVF;
  logic        ERR_CLR = 1'b0;

  int checks = 0;
  int passes = 0;

  logic [13:0] wa_q [$];
  logic [7:0]  wd_q [$];

  typedef struct {
    logic [1:0]  px;
    logic        valid;
    logic [1:0]  mode;
    logic        ready;
    logic        clr;
    logic        exp_wr;
    logic [13:0] exp_addr;
    logic [7:0]  exp_data;
    logic        exp_lerr;
  } vec_t;

  vec_t tbl [11];

  ppu_fb_writer dut (
    .clk        (clk),
    .rst        (rst),
    .PX_OUT     (PX_OUT),
    .PX_valid   (PX_valid),
    .PPU_MODE   (PPU_MODE),
    .FB_WR      (FB_WR),
    .FB_ADDR    (FB_ADDR),
    .FB_DATA    (FB_DATA),
    .FB_READY   (FB_READY),
    .FB_BANK    (FB_BANK),
    .FRAME_DONE (FRAME_DONE),
    .LINE_ERR   (LINE_ERR),
    .OVF        (OVF),
    .ERR_CLR    (ERR_CLR)
  );

  always #5 clk = ~clk;

  // Record every accepted write mid-cycle, when inputs and outputs are settled
  always @(negedge clk) begin
    if (!rst && FB_WR && FB_READY) begin
      wa_q.push_back(FB_ADDR);
      wd_q.push_back(FB_DATA);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] px, input logic v, input logic [1:0] m,
                               input logic rdy, input logic clr);
    PX_OUT   = px;
    PX_valid = v;
    PPU_MODE = m;
    FB_READY = rdy;
    ERR_CLR  = clr;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(2'd0, 1'b0, M_VB, 1'b0, 1'b0);
    applyStimulus(2'd0, 1'b0, M_VB, 1'b0, 1'b0);
    rst = 1'b0;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wr"},   16'(FB_WR),      16'd0);
    checkOutput({tag, "_addr"}, 16'(FB_ADDR),    16'd0);
    checkOutput({tag, "_data"}, 16'(FB_DATA),    16'd0);
    checkOutput({tag, "_bank"}, 16'(FB_BANK),    16'd0);
    checkOutput({tag, "_fd"},   16'(FRAME_DONE), 16'd0);
    checkOutput({tag, "_lerr"}, 16'(LINE_ERR),   16'd0);
    checkOutput({tag, "_ovf"},  16'(OVF),        16'd0);
  endtask

  // One full-width line with pixels 0,1,2,3 repeating, bracketed by SCAN and H_BLANK
  task automatic fullLine();
    applyStimulus(2'd0, 1'b0, M_SCAN, 1'b1, 1'b0);
    for (int i = 0; i < 160; i++) applyStimulus(2'(i % 4), 1'b1, M_DRAW, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, M_HB, 1'b1, 1'b0);
  endtask

  initial begin
    int bad;

    tbl[0]  = '{2'd0, 1'b0, M_SCAN, 1'b0, 1'b0, 1'b0, 14'd0, 8'h00, 1'b0};
    tbl[1]  = '{2'd3, 1'b1, M_DRAW, 1'b0, 1'b0, 1'b0, 14'd0, 8'h00, 1'b0};
    tbl[2]  = '{2'd3, 1'b1, M_DRAW, 1'b0, 1'b0, 1'b0, 14'd0, 8'h00, 1'b0};
    tbl[3]  = '{2'd3, 1'b1, M_DRAW, 1'b0, 1'b0, 1'b0, 14'd0, 8'h00, 1'b0};
    tbl[4]  = '{2'd3, 1'b1, M_DRAW, 1'b1, 1'b0, 1'b1, 14'd0, 8'hFF, 1'b0};
    tbl[5]  = '{2'd3, 1'b1, M_DRAW, 1'b1, 1'b0, 1'b0, 14'd0, 8'h00, 1'b0};
    tbl[6]  = '{2'd3, 1'b1, M_DRAW, 1'b1, 1'b0, 1'b0, 14'd0, 8'h00, 1'b0};
    tbl[7]  = '{2'd0, 1'b1, M_HB,   1'b0, 1'b0, 1'b1, 14'd1, 8'hF0, 1'b1};
    tbl[8]  = '{2'd0, 1'b0, M_HB,   1'b0, 1'b0, 1'b1, 14'd1, 8'hF0, 1'b1};
    tbl[9]  = '{2'd0, 1'b0, M_HB,   1'b1, 1'b0, 1'b0, 14'd0, 8'h00, 1'b1};
    tbl[10] = '{2'd0, 1'b0, M_HB,   1'b1, 1'b1, 1'b0, 14'd0, 8'h00, 1'b0};

    resetDut();
    checkResetOutputs("reset");

    // Full line, then the first group of the next line must land at row 1
    resetDut();
    applyStimulus(2'd0, 1'b0, M_SCAN, 1'b1, 1'b0);
    for (int i = 0; i < 160; i++) begin
      applyStimulus(2'(i % 4), 1'b1, M_DRAW, 1'b1, 1'b0);
      if (i == 3) begin
        checkOutput("latency_wr",   16'(FB_WR),   16'd1);
        checkOutput("latency_addr", 16'(FB_ADDR), 16'd0);
        checkOutput("latency_data", 16'(FB_DATA), 16'h1B);
      end
    end
    applyStimulus(2'd0, 1'b0, M_HB, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, M_HB, 1'b1, 1'b0);
    checkOutput("line_count", 16'(wa_q.size()), 16'd40);
    for (int j = 0; j < wa_q.size(); j++) begin
      checkOutput($sformatf("line_addr%0d", j), 16'(wa_q[j]), 16'(j));
      checkOutput($sformatf("line_data%0d", j), 16'(wd_q[j]), 16'h1B);
    end
    checkOutput("line_lerr", 16'(LINE_ERR), 16'd0);
    wa_q.delete();
    wd_q.delete();
    applyStimulus(2'd0, 1'b0, M_SCAN, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(2'(i % 4), 1'b1, M_DRAW, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, M_HB, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, M_HB, 1'b1, 1'b0);
    checkOutput("row1_count", 16'(wa_q.size()), 16'd1);
    if (wa_q.size() > 0) checkOutput("row1_addr", 16'(wa_q[0]), 16'd40);

    // Short line with stall, driven from the vector table
    resetDut();
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].px, tbl[i].valid, tbl[i].mode, tbl[i].ready, tbl[i].clr);
      checkOutput($sformatf("vec%0d_wr", i),   16'(FB_WR),    16'(tbl[i].exp_wr));
      checkOutput($sformatf("vec%0d_lerr", i), 16'(LINE_ERR), 16'(tbl[i].exp_lerr));
      if (tbl[i].exp_wr) begin
        checkOutput($sformatf("vec%0d_addr", i), 16'(FB_ADDR), 16'(tbl[i].exp_addr));
        checkOutput($sformatf("vec%0d_data", i), 16'(FB_DATA), 16'(tbl[i].exp_data));
      end
    end

    // Backpressure: six bytes offered to a four-entry queue with the RAM stalled
    resetDut();
    applyStimulus(2'd0, 1'b0, M_SCAN, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      applyStimulus(2'(i % 4), 1'b1, M_DRAW, 1'b0, 1'b0);
      if (i >= 3) begin
        checkOutput("stall_addr", 16'(FB_ADDR), 16'd0);
        checkOutput("stall_data", 16'(FB_DATA), 16'h1B);
      end
    end
    checkOutput("stall_wr",  16'(FB_WR), 16'd1);
    checkOutput("stall_ovf", 16'(OVF),   16'd1);
    applyStimulus(2'd0, 1'b0, M_HB, 1'b0, 1'b0);
    checkOutput("stall_hold_addr", 16'(FB_ADDR), 16'd0);
    for (int i = 0; i < 8; i++) applyStimulus(2'd0, 1'b0, M_HB, 1'b1, 1'b0);
    checkOutput("drain_count", 16'(wa_q.size()), 16'd4);
    for (int j = 0; j < wa_q.size(); j++)
      checkOutput($sformatf("drain_addr%0d", j), 16'(wa_q[j]), 16'(j));
    checkOutput("ovf_sticky", 16'(OVF), 16'd1);
    applyStimulus(2'd0, 1'b0, M_HB, 1'b0, 1'b1);
    checkOutput("ovf_clr",  16'(OVF),      16'd0);
    checkOutput("lerr_clr", 16'(LINE_ERR), 16'd0);

    // Filtering: stray valids outside DRAW and a 161st pixel must be ignored
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(2'd1, 1'b1, M_SCAN, 1'b1, 1'b0);
    for (int i = 0; i < 161; i++) applyStimulus(2'd2, 1'b1, M_DRAW, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(2'd1, 1'b1, M_HB, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(2'd1, 1'b1, M_SCAN, 1'b1, 1'b0);
    checkOutput("filt_count", 16'(wa_q.size()), 16'd40);
    bad = 0;
    for (int j = 0; j < wa_q.size(); j++) if (wd_q[j] !== 8'hAA || wa_q[j] !== 14'(j)) bad++;
    checkOutput("filt_bad_entries", 16'(bad), 16'd0);
    checkOutput("filt_lerr", 16'(LINE_ERR), 16'd0);

    // Whole frame into bank 0, then bank switch
    resetDut();
    for (int l = 0; l < 144; l++) fullLine();
    applyStimulus(2'd0, 1'b0, M_VB, 1'b1, 1'b0);
    checkOutput("frame_done_hi", 16'(FRAME_DONE), 16'd1);
    checkOutput("frame_bank1",   16'(FB_BANK),    16'd1);
    applyStimulus(2'd0, 1'b0, M_VB, 1'b1, 1'b0);
    checkOutput("frame_done_lo", 16'(FRAME_DONE), 16'd0);
    checkOutput("frame_count", 16'(wa_q.size()), 16'd5760);
    bad = 0;
    for (int j = 0; j < wa_q.size(); j++) if (wa_q[j] !== 14'(j) || wd_q[j] !== 8'h1B) bad++;
    checkOutput("frame_bad_entries", 16'(bad), 16'd0);
    if (wa_q.size() > 0) checkOutput("frame_last_addr", 16'(wa_q[wa_q.size()-1]), 16'd5759);
    wa_q.delete();
    wd_q.delete();

    // Bank-1 short line ending directly in V_BLANK, then back to bank 0 at row 0
    applyStimulus(2'd0, 1'b0, M_SCAN, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(2'd3, 1'b1, M_DRAW, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, M_VB, 1'b1, 1'b0);
    checkOutput("f2_done", 16'(FRAME_DONE), 16'd1);
    checkOutput("f2_bank", 16'(FB_BANK),    16'd0);
    checkOutput("f2_lerr", 16'(LINE_ERR),   16'd1);
    applyStimulus(2'd0, 1'b0, M_VB, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, M_SCAN, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(2'(i % 4), 1'b1, M_DRAW, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, M_HB, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, M_HB, 1'b1, 1'b0);
    checkOutput("f2_count", 16'(wa_q.size()), 16'd3);
    if (wa_q.size() == 3) begin
      checkOutput("f2_addr0", 16'(wa_q[0]), 16'd5760);
      checkOutput("f2_data0", 16'(wd_q[0]), 16'hFF);
      checkOutput("f2_addr1", 16'(wa_q[1]), 16'd5761);
      checkOutput("f2_data1", 16'(wd_q[1]), 16'hF0);
      checkOutput("f3_addr0", 16'(wa_q[2]), 16'd0);
      checkOutput("f3_data0", 16'(wd_q[2]), 16'h1B);
    end

    // Reset mid-line with three bytes queued and a partial byte pending
    resetDut();
    applyStimulus(2'd0, 1'b0, M_SCAN, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) applyStimulus(2'd3, 1'b1, M_DRAW, 1'b0, 1'b0);
    checkOutput("pre_rst_wr", 16'(FB_WR), 16'd1);
    rst = 1'b1;
    applyStimulus(2'd0, 1'b0, M_DRAW, 1'b0, 1'b0);
    checkResetOutputs("midrst");
    rst = 1'b0;
    applyStimulus(2'd2, 1'b1, M_DRAW, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(2'd0, 1'b1, M_DRAW, 1'b0, 1'b0);
    checkOutput("post_rst_wr",   16'(FB_WR),   16'd1);
    checkOutput("post_rst_addr", 16'(FB_ADDR), 16'd0);
    checkOutput("post_rst_data", 16'(FB_DATA), 16'h80);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ppu_fb_writer.md
Name: ppu_fb_writer

Overview:
- Sink for the PPU pixel stream: consumes the 2-bit pixels (PX_OUT/PX_valid) plus PPU_MODE.
- Tracks the screen position (x 0..159, y 0..143) and packs 4 pixels per byte.
- Buffers packed bytes in a small FIFO, then writes them to a 160x144 2bpp framebuffer RAM through a valid/ready write port.
- Optional double buffering lets the display scan-out side read a completed frame while the next one is written.

Parameters:
- FIFO_DEPTH, 4, packed-byte FIFO entries (power of 2, >=2)
- DOUBLE_BUF, 1, 1 = toggle FB_BANK every frame; 0 = FB_BANK fixed at 0
- BANK_STRIDE, 5760, byte offset between bank 0 and bank 1 (160*144/4)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- PX_OUT  in  2  pixel colour index from PPU
- PX_valid  in  1  PX_OUT valid this cycle
- PPU_MODE  in  2  0=H_BLANK, 1=V_BLANK, 2=SCAN, 3=DRAW
- FB_WR  out  1  write request; FIFO head valid
- FB_ADDR  out  14  byte address = bank*BANK_STRIDE + y*40 + x/4
- FB_DATA  out  8  packed byte {p0,p1,p2,p3}, p0 (leftmost) in [7:6]
- FB_READY  in  1  RAM accepts write this cycle
- FB_BANK  out  1  bank currently being written
- FRAME_DONE  out  1  one-cycle pulse when a frame completes
- LINE_ERR  out  1  sticky: a line ended with x != 160
- OVF  out  1  sticky: packed byte dropped because FIFO full
- ERR_CLR  in  1  clears LINE_ERR and OVF

Behaviour:
- Reset: x=0, y=0, pack index k=0, FIFO empty, FB_WR=0, FB_ADDR=0, FB_DATA=0, FB_BANK=0, FRAME_DONE=0, LINE_ERR=0, OVF=0. prev_mode register = V_BLANK. Reset mid-frame discards FIFO contents and any partial byte.
- Pixel accept: on each edge with PX_valid=1 and PPU_MODE=DRAW and x<160:
  - pixel goes into slot k of the shift byte; k++, x++.
  - Pixels with x>=160, or with PX_valid=1 outside DRAW, are ignored.
- Pack: when the 4th pixel (k=3) is accepted, {byte, address} is pushed on that same edge. Address is computed from the x of the first pixel in the group. k wraps to 0.
- Latency: 4th pixel sampled at edge E -> FB_WR=1 with that entry at the head in the cycle after E (1 cycle), if the FIFO was empty.
- Write port:
  - FB_WR = FIFO not empty; FB_ADDR/FB_DATA = head entry.
  - Head pops on an edge where FB_WR && FB_READY.
  - FB_ADDR/FB_DATA must hold stable while FB_WR=1 and FB_READY=0.
- FIFO full:
  - Push with no pop in the same cycle -> byte dropped, OVF<=1.
  - Push and pop in the same cycle -> push accepted, count unchanged.
- Line end (prev_mode=DRAW and PPU_MODE!=DRAW):
  - If k!=0, push the partial byte with empty slots zero, under the same full rule.
  - If x!=160, LINE_ERR<=1.
  - x<=0, k<=0; y<=y+1 if y<143, else hold y at 143.
- Frame end (prev_mode!=V_BLANK and PPU_MODE=V_BLANK):
  - FRAME_DONE pulses 1 cycle; y<=0.
  - FB_BANK toggles if DOUBLE_BUF=1. The toggle affects addresses of subsequent pushes only; queued entries keep their captured address.
- Line end and frame end on the same edge: do line end first, then frame end (y ends at 0).
- ERR_CLR on the same edge as a new error event: the error wins (flag stays 1).
- Address width: y*40 computed in 14 bits. Max address = 5760+5759 = 11519 < 2^14.

Test Plan:
- Full line: DRAW with 160 consecutive valid pixels repeating 0,1,2,3, FB_READY=1 -> 40 writes of 0x1B at addresses 0..39; LINE_ERR=0; y=1 after H_BLANK.
- Backpressure: FB_READY=0 while 24 pixels arrive -> first FIFO_DEPTH(4) bytes queued, 2 dropped, OVF=1. Then FB_READY=1 -> exactly 4 writes, addresses 0..3 stable throughout the stall. ERR_CLR -> OVF=0.
- Short line: 6 pixels of value 3 then mode H_BLANK -> writes 0xFF@0, then 0xF0@1; LINE_ERR=1.
- Frame: 144 full lines, then V_BLANK -> FRAME_DONE 1-cycle pulse, FB_BANK=1. The next frame's first write goes to 5760; the last write of frame 0 goes to 5759.
- Filtering: PX_valid=1 during SCAN/H_BLANK, plus a 161st pixel in DRAW -> no extra writes, x stays 160.
- Reset mid-line after 2 pixels with 3 bytes queued -> FB_WR=0 next cycle, all outputs at reset values, next accepted pixel lands at address 0, slot [7:6].
